// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with prefetch FIFO, in-order memory requests and redirect squash; FETCH_BYPASS_EN enables zero-latency response bypass
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_resp_valid,
    input  logic [31:0] i_mem_resp_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_insn,
    output logic [31:0] o_pc
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   pc;
    logic [CW-1:0] inflight, drop, count;
    logic [AW-1:0] tag_rd, tag_wr, rd_ptr, wr_ptr;
    logic [31:0]   tag_q  [FIFO_DEPTH];
    logic [31:0]   insn_q [FIFO_DEPTH];
    logic [31:0]   pc_q   [FIFO_DEPTH];
    logic          req_fire, fifo_empty, accept, bypass, push, pop, unused;

    assign unused          = ^i_redirect_pc[1:0];
    assign o_mem_req_valid = !rst && !i_redirect && ({1'b0, inflight} + {1'b0, count} < DEPTH_C);
    assign o_mem_addr      = pc;
    assign req_fire        = o_mem_req_valid && i_mem_req_ready;
    assign fifo_empty      = count == '0;
    assign accept          = i_mem_resp_valid && !i_redirect && drop == '0;
`ifdef FETCH_BYPASS_EN
    assign bypass          = accept && fifo_empty && !rst;
`else
    assign bypass          = 1'b0;
`endif
    assign push            = accept && !(bypass && i_ready);
    assign pop             = !fifo_empty && i_ready;
    assign o_valid         = !fifo_empty || bypass;
    assign o_insn          = bypass ? i_mem_resp_data : insn_q[rd_ptr];
    assign o_pc            = bypass ? tag_q[tag_rd] : pc_q[rd_ptr];

    // fetch PC, outstanding-request count and stale-response drop count
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            pc       <= i_redirect ? {i_redirect_pc[31:2], 2'b00} : req_fire ? pc + 32'd4 : pc;
            inflight <= inflight + CW'(req_fire) - CW'(i_mem_resp_valid);
            drop     <= i_redirect ? inflight - CW'(i_mem_resp_valid) : drop - CW'(i_mem_resp_valid && drop != '0);
        end
    end

    // pc tag of every in-flight request, retired in response order
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_rd <= '0;
            tag_wr <= '0;
        end else begin
            if (req_fire) begin
                tag_q[tag_wr] <= pc;
                tag_wr        <= tag_wr + AW'(1);
            end
            if (i_mem_resp_valid)
                tag_rd <= tag_rd + AW'(1);
        end
    end

    // prefetch FIFO of {insn, pc}; emptied by redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                insn_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (i_redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                insn_q[wr_ptr] <= i_mem_resp_data;
                pc_q[wr_ptr]   <= tag_q[tag_rd];
                wr_ptr         <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifndef SYNTHESIS
    // a response must always match an outstanding request
    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(i_mem_resp_valid && inflight == '0));
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus random traffic against a sequential-PC stream model
module tb_fetch_unit;
    logic        clk, rst, i_redirect, i_mem_req_ready, i_mem_resp_valid, i_ready;
    logic [31:0] i_redirect_pc, i_mem_resp_data;
    logic        o_mem_req_valid, o_valid;
    logic [31:0] o_mem_addr, o_insn, o_pc;

`ifdef FETCH_BYPASS_EN
    localparam logic [31:0] BYP = 32'd1;
`else
    localparam logic [31:0] BYP = 32'd0;
`endif
    localparam logic [31:0] RPC = 32'h100;

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready), .o_mem_addr(o_mem_addr),
        .i_mem_resp_valid(i_mem_resp_valid), .i_mem_resp_data(i_mem_resp_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_insn(o_insn), .o_pc(o_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int cyc = 0, nfire = 0, nout = 0;
    int req_pct, resp_pct, rdy_pct;
    logic [31:0] pend_addr[$];
    int          pend_cyc[$];
    logic [31:0] exp_req, exp_out;
    logic        s_valid, s_req, saw_wrap;
    logic [31:0] s_addr, s_pc, s_insn;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        logic rv;
        rv = !rst && pend_addr.size() != 0 && pend_cyc[0] < cyc && $urandom_range(99) < resp_pct;
        i_mem_resp_valid = rv;
        i_mem_resp_data  = rv ? mem_word(pend_addr[0]) : $urandom;
        i_mem_req_ready  = $urandom_range(99) < req_pct;
        i_ready          = $urandom_range(99) < rdy_pct;
        @(negedge clk);
        s_valid = o_valid; s_req = o_mem_req_valid; s_addr = o_mem_addr; s_pc = o_pc; s_insn = o_insn;
        if (!rst) begin
            if (i_redirect) chk("req_in_redirect", s_req, 0);
            if (s_req) chk("req_addr", s_addr, exp_req);
            if (s_req && i_mem_req_ready) begin
                pend_addr.push_back(s_addr);
                pend_cyc.push_back(cyc);
                if (s_addr == 0) saw_wrap = 1'b1;
                exp_req += 4;
                nfire++;
            end
            if (s_valid && i_ready) begin
                chk("out_pc", s_pc, exp_out);
                chk("out_insn", s_insn, mem_word(exp_out));
                exp_out += 4;
                nout++;
            end
            if (rv) begin
                void'(pend_addr.pop_front());
                void'(pend_cyc.pop_front());
            end
            if (i_redirect) begin
                exp_req = {i_redirect_pc[31:2], 2'b00};
                exp_out = exp_req;
            end
            chk("credit", 32'(pend_addr.size() <= 2), 1);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        req_pct = 0; resp_pct = 100; rdy_pct = 100;
        repeat (8) cycle();
        chk("drain_pend", pend_addr.size(), 0);
        chk("drain_valid", s_valid, 0);
    endtask

    task automatic restart();
        pend_addr.delete();
        pend_cyc.delete();
        exp_req = RPC;
        exp_out = RPC;
    endtask

    initial begin
        int n;
        rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0;
        req_pct = 100; resp_pct = 100; rdy_pct = 100; saw_wrap = 1'b0;
        restart();
        cycle();
        cycle();
        chk("rst_valid", s_valid, 0);
        chk("rst_req", s_req, 0);
        chk("rst_insn", s_insn, 0);
        chk("rst_pc", s_pc, 0);
        rst = 1'b0;
        restart();
        cycle();
        chk("lat_c0_req", s_req, 1);
        chk("lat_c0_addr", s_addr, RPC);
        chk("lat_c0_valid", s_valid, 0);
        cycle();
        chk("lat_c1_valid", s_valid, BYP);
        chk("lat_c1_addr", s_addr, RPC + 4);
        cycle();
        chk("lat_c2_valid", s_valid, 1);
        n = nout;
        repeat (20) cycle();
        chk("s1_progress", 32'(nout - n >= 5), 1);
        drain();
        req_pct = 100; rdy_pct = 0; resp_pct = 100;
        n = nfire;
        repeat (10) cycle();
        chk("s2_reqs", nfire - n, 2);
        chk("s2_stall", s_req, 0);
        n = nout;
        req_pct = 0; rdy_pct = 100;
        repeat (6) cycle();
        chk("s2_drained", nout - n, 2);
        drain();
        req_pct = 100; resp_pct = 0; rdy_pct = 100;
        repeat (2) cycle();
        chk("s3_inflight", pend_addr.size(), 2);
        i_redirect = 1'b1; i_redirect_pc = 32'h2002;
        cycle();
        i_redirect = 1'b0; resp_pct = 100;
        n = nout;
        repeat (12) cycle();
        chk("s3_out", 32'(nout > n), 1);
        drain();
        req_pct = 100; resp_pct = 0; rdy_pct = 100;
        cycle();
        i_redirect = 1'b1; i_redirect_pc = 32'h3001; resp_pct = 100;
        cycle();
        i_redirect = 1'b0;
        cycle();
        chk("s4_next_req", s_req, 1);
        chk("s4_next_addr", s_addr, 32'h3000);
        repeat (10) cycle();
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFF8;
        cycle();
        i_redirect = 1'b0; saw_wrap = 1'b0;
        repeat (12) cycle();
        chk("s5_wrap", saw_wrap, 1);
        rdy_pct = 0;
        repeat (8) cycle();
        chk("s6_full", s_valid, 1);
        rst = 1'b1;
        cycle();
        cycle();
        chk("s6_valid", s_valid, 0);
        chk("s6_req", s_req, 0);
        rst = 1'b0;
        restart();
        rdy_pct = 100;
        cycle();
        chk("s6_resume_req", s_req, 1);
        chk("s6_resume_addr", s_addr, RPC);
        n = nout;
        for (int k = 0; k < 3000; k++) begin
            if (k == 0)    begin req_pct = 70;  resp_pct = 60;  rdy_pct = 70;  end
            if (k == 1000) begin req_pct = 100; resp_pct = 100; rdy_pct = 100; end
            if (k == 2000) begin req_pct = 40;  resp_pct = 40;  rdy_pct = 30;  end
            i_redirect = $urandom_range(99) < 3;
            i_redirect_pc = $urandom;
            cycle();
        end
        i_redirect = 1'b0;
        drain();
        chk("rand_progress", 32'(nout - n > 100), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
